// File: rtl/aes_inv_keyschedule.sv
// aes_inv_keyschedule
//
// Iterative AES-128 inverse key schedule. A start captures the round-10
// key, then each accepted output steps the schedule back one round, so
// the consumer sees round keys 10, 9, ..., 0 in order. Round 0 is the
// original cipher key.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   load request, honoured only while idle
//   key_in     in   [15:0][7:0] round-10 key, byte i = FIPS byte i
//   busy       out  walk in progress (start accepted, round 0 not yet taken)
//   out_valid  out  round_key / round_idx presented
//   out_ready  in   consumer accepts the presented key
//   round_key  out  [15:0][7:0] current round key, same byte order as key_in
//   round_idx  out  [3:0] round number of round_key, 10..0
//   done       out  one-cycle pulse after the round-0 key is accepted

module aes_inv_keyschedule (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0][7:0] key_in,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0][7:0] round_key,
  output logic [3:0]       round_idx,
  output logic             done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  // Forward AES S-box: the inverse schedule still runs SubWord forwards.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant used to undo round r (r = 1..10).
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  logic [0:0]       r_state;
  logic [15:0][7:0] r_key;
  logic [3:0]       r_round;
  logic             r_done;

  logic [3:0][7:0]  w_p3;
  logic [3:0][7:0]  w_p2;
  logic [3:0][7:0]  w_p1;
  logic [3:0][7:0]  w_p0;
  logic [15:0][7:0] w_prev_key;

  // Upper three previous words are plain XORs of adjacent current words.
  assign w_p3 = r_key[15:12] ^ r_key[11:8];
  assign w_p2 = r_key[11:8]  ^ r_key[7:4];
  assign w_p1 = r_key[7:4]   ^ r_key[3:0];

  // Word 0 needs SubWord(RotWord(p3)); RotWord moves byte 0 to the end,
  // so output byte b takes p3 byte (b+1) mod 4. Rcon lands on byte 0.
  assign w_p0[0] = r_key[0] ^ SBOX[w_p3[1]] ^ rcon(r_round);
  assign w_p0[1] = r_key[1] ^ SBOX[w_p3[2]];
  assign w_p0[2] = r_key[2] ^ SBOX[w_p3[3]];
  assign w_p0[3] = r_key[3] ^ SBOX[w_p3[0]];

  assign w_prev_key = {w_p3, w_p2, w_p1, w_p0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_round <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key   <= key_in;
            r_round <= 4'd10;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          // out_valid is implied in EMIT, so out_ready alone is the handshake.
          if (out_ready) begin
            if (r_round == 4'd0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_key   <= w_prev_key;
              r_round <= r_round - 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_EMIT);
  assign out_valid = (r_state == S_EMIT);
  assign round_key = r_key;
  assign round_idx = r_round;
  assign done      = r_done;

endmodule

// File: tb/tb_aes_inv_keyschedule.sv
// tb_aes_inv_keyschedule
//
// Bench for aes_inv_keyschedule. The reference model works on FIPS-order
// 128-bit keys (byte 0 is the most significant byte of the hex literal),
// derives the S-box from GF(2^8) inversion plus the affine map, and
// builds all eleven round keys backwards from the round-10 key.

module tb_aes_inv_keyschedule;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [15:0][7:0] key_in;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [15:0][7:0] round_key;
  logic [3:0]       round_idx;
  logic             done;

  int n_tests;
  int n_fail;

  logic [127:0] exp_keys [0:10];
  logic [127:0] obs_keys [0:10];

  aes_inv_keyschedule dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] d = {a, a};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] a);
    logic [7:0] b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
  endfunction

  function automatic logic [127:0] prev_key(input logic [127:0] k, input int rnd);
    logic [31:0] w0 = k[127:96];
    logic [31:0] w1 = k[95:64];
    logic [31:0] w2 = k[63:32];
    logic [31:0] w3 = k[31:0];
    logic [31:0] p3 = w3 ^ w2;
    logic [7:0]  rc = 8'h01;
    for (int i = 1; i < rnd; i++) rc = xtime(rc);
    return {w0 ^ subword({p3[23:0], p3[31:24]}) ^ {rc, 24'h0}, w1 ^ w0, w2 ^ w1, p3};
  endfunction

  task automatic gen_keys(input logic [127:0] k10);
    exp_keys[10] = k10;
    for (int r = 10; r > 0; r--) exp_keys[r-1] = prev_key(exp_keys[r], r);
  endtask

  // FIPS-order hex <-> packed byte-array order (involution).
  function automatic logic [127:0] flip(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = x[8*i +: 8];
    return y;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: requests a load on the next rising edge and
  // returns at the falling edge of the cycle that should show round 10.
  task automatic begin_walk(input logic [127:0] k);
    gen_keys(k);
    start  = 1'b1;
    key_in = flip(k);
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Walks 10..0 with out_ready high; optionally fires a start with another
  // key while round inj_r is shown. Returns in the done cycle.
  task automatic run_walk(input string tag, input int inj_r, input logic [127:0] inj_k);
    for (int r = 10; r >= 0; r--) begin
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_idx"}, round_idx, r);
      check({tag, "_key"}, flip(round_key), exp_keys[r]);
      obs_keys[r] = flip(round_key);
      if (r == inj_r) begin
        start  = 1'b1;
        key_in = flip(inj_k);
      end else begin
        start  = 1'b0;
        key_in = flip(128'h0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_valid_end"}, out_valid, 1'b0);
  endtask

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  initial begin
    logic [127:0] rk;
    logic [127:0] held;
    int           exp_r;
    int           stalls;
    int           busy_cyc;
    int           acc;
    bit           got_done;
    bit           was_stall;
    bit           rdy;

    n_tests   = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    key_in    = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_idx", round_idx, 4'd0);
    check("rst_key", round_key, 128'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // FIPS-197 walk
    begin_walk(FIPS_K10);
    run_walk("fips", -1, 128'h0);
    check("fips_r10", obs_keys[10], FIPS_K10);
    check("fips_r9", obs_keys[9], 128'hac7766f3_19fadc21_28d12941_575c006e);
    check("fips_r1", obs_keys[1], 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    check("fips_r0", obs_keys[0], 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);

    // Back-to-back: start in the done cycle with the zero-key vector
    begin_walk(ZERO_K10);
    run_walk("zero", -1, 128'h0);
    check("zero_r1", obs_keys[1], 128'h62636363_62636363_62636363_62636363);
    check("zero_r0", obs_keys[0], 128'h0);
    @(negedge clk);
    check("done_pulse_len", done, 1'b0);

    // Start while busy: second key offered at round 5 must be ignored
    rk = {$urandom, $urandom, $urandom, $urandom};
    begin_walk(rk);
    run_walk("busy_start", 5, {$urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    check("busy_start_idle", busy, 1'b0);

    // Backpressure with random out_ready
    for (int pass = 0; pass < 3; pass++) begin
      rk        = {$urandom, $urandom, $urandom, $urandom};
      exp_r     = 10;
      stalls    = 0;
      busy_cyc  = 0;
      acc       = 0;
      got_done  = 1'b0;
      was_stall = 1'b0;
      held      = '0;
      out_ready = 1'b0;
      begin_walk(rk);
      for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
        if (done) begin
          got_done = 1'b1;
        end else begin
          if (busy) busy_cyc++;
          if (out_valid) begin
            if (exp_r < 0) begin
              check("bp_extra_valid", out_valid, 1'b0);
            end else begin
              check("bp_idx", round_idx, exp_r);
              check("bp_key", flip(round_key), exp_keys[exp_r]);
              if (was_stall) check("bp_hold", round_key, held);
            end
          end
          rdy = 1'($urandom_range(0, 1));
          if (out_valid && rdy) begin
            acc++;
            exp_r--;
            was_stall = 1'b0;
          end else if (out_valid) begin
            stalls++;
            was_stall = 1'b1;
            held      = round_key;
          end
          out_ready = rdy;
          @(negedge clk);
        end
      end
      check("bp_done_seen", got_done, 1'b1);
      check("bp_accepts", acc, 11);
      check("bp_busy_cycles", busy_cyc, 11 + stalls);
      out_ready = 1'b1;
      @(negedge clk);
    end

    // Reset mid-walk at round 4, then a clean restart
    rk = {$urandom, $urandom, $urandom, $urandom};
    begin_walk(rk);
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("mid_idx_before_rst", round_idx, 4'd4);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_idx", round_idx, 4'd0);
    check("mid_rst_key", round_key, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", busy, 1'b0);
    rk = {$urandom, $urandom, $urandom, $urandom};
    begin_walk(rk);
    run_walk("restart", -1, 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
